lattice_sched: RTL and testbench
================================

// Module: lattice_sched
// PURPOSE
//  Sequences backward induction over the binomial lattice for the American put pricer.
//  Leaf values sit in a ping-pong value RAM, bank 0 word j = level N_STEPS node j.
//  Each level is produced by streaming node pairs (v_down = node j, v_up = node j+1) through the node-evaluation pipeline.
//  Each node result is written to the opposite bank. The pipeline covers RAM read, multiply, add, compare and select.
//  After level 0 is written the root word holds the option price.
// PARAMETERS
//  N_STEPS   64  lattice depth (levels N_STEPS-1..0 computed); legal range 1..2**ADDR_W-1
//  ADDR_W    7   value-RAM word address width per bank
//  PIPE_LAT  14  cycles from rd_en (issue) to result valid at RAM write port (RAM read + eval pipeline); >=1
// PORTS
//  clk         in   1       single clock, all logic rising-edge
//  nrst        in   1       asynchronous active-low reset
//  start       in   1       pulse: begin induction; ignored unless idle
//  rd_en       out  1       issue one node: read both child words this cycle
//  rd_bank     out  1       bank holding the child level
//  rd_addr_dn  out  ADDR_W  child index j (down move)
//  rd_addr_up  out  ADDR_W  child index j+1 (up move)
//  vex_level   out  ADDR_W  level i of issued node (to exercise-value generator, same cycle as rd_en)
//  vex_node    out  ADDR_W  node index j of issued node
//  wr_en       out  1       write node result this cycle
//  wr_bank     out  1       destination bank (= rd_bank of matching issue, inverted)
//  wr_addr     out  ADDR_W  destination node index j
//  busy        out  1       high from cycle after accepted start until done
//  done        out  1       one-cycle pulse after root write
//  root_bank   out  1       bank holding root price: N_STEPS[0]; constant
// BEHAVIOUR
//  Reset: all outputs 0 except root_bank (constant); FSM=IDLE; delay line valids cleared.
//  Reset mid-run: immediate abort. No partial writes complete after nrst rises.
//  FSM states IDLE, ISSUE, DRAIN, DONE:
//   IDLE : start=1 -> ISSUE with level=N_STEPS-1, j=0, src bank=0.
//   ISSUE: rd_en=1 every cycle with j=0..level. The source bank is rd_bank.
//          After j==level issues -> DRAIN.
//   DRAIN: rd_en=0. Wait until the last write of this level has been presented (wr_en for j==level).
//          If level==0 -> DONE. Otherwise level-1, j=0, toggle src bank -> ISSUE on the following cycle.
//   DONE : done=1 for one cycle, busy drops same cycle -> IDLE.
//  A start seen while not IDLE has no effect (no queueing).
//  Write path: PIPE_LAT-deep shift register of {valid, bank, j}, loaded at issue.
//   wr_en/wr_bank/wr_addr equal the issue cycle's values delayed exactly PIPE_LAT cycles.
//  Ordering: no read of level i may issue before every write of level i.
//   Required because the RAW distance is unbounded across a level boundary.
//  Throughput: level i takes (i+1) issue cycles + PIPE_LAT drain cycles.
//   Total cycles start->done = sum_{i=0}^{N_STEPS-1}(i+1+PIPE_LAT) + 2.
//  Counters: level and j are ADDR_W bits. j never exceeds level, so there is no wrap.
//   rd_addr_up = j+1 <= N_STEPS fits ADDR_W.
//  busy=1 from the cycle after start is sampled through the done cycle. At most one wr_en per cycle.
// TESTING
//  Case 1, N_STEPS=2, PIPE_LAT=3, start at cycle 0:
//   rd_en cycles 1,2: bank0, dn/up=(0,1),(1,2); vex (1,0),(1,1).
//   wr_en cycles 4,5: bank1, addr 0,1.
//   rd_en cycle 6: bank1, (0,1), vex (0,0). wr_en cycle 9: bank0 addr0.
//   done pulse cycle 10; root_bank=0.
//  Case 2, N_STEPS=1, PIPE_LAT=1: single issue at cycle 1 (bank0, 0/1); wr cycle 2 bank1 addr0; done cycle 3; root_bank=1.
//  Case 3, busy start: start pulses during ISSUE and DRAIN of case 1 -> no change to any output trace; one done only.
//  Case 4, reset mid-run: nrst low during cycle 5 of case 1 -> all outputs 0 immediately; no wr_en afterwards.
//   A new start then reproduces the case 1 trace exactly.
//  Case 5, golden model: N_STEPS=64, PIPE_LAT=14, behavioural RAM + eval model -> root equals reference put price.
//   Check the done cycle matches the total-cycle formula. Assert no read of a bank/address with a pending write.

Source files
------------

// File: rtl/lattice_sched.sv
`default_nettype none
// ============================================================================
// Module      : lattice_sched
// Description : Backward-induction sequencer for the binomial-lattice American
//               put pricer. Each lattice level is issued as node pairs read from
//               one ping-pong bank. Results are written to the other bank through
//               a fixed-latency delay line. A level starts only after the
//               previous level has been fully written.
// Revision    : 1.0 - initial release
// ============================================================================
module lattice_sched #(
  parameter int N_STEPS  = 64,
  parameter int ADDR_W   = 7,
  parameter int PIPE_LAT = 14
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr_dn,
  output logic [ADDR_W-1:0] rd_addr_up,
  output logic [ADDR_W-1:0] vex_level,
  output logic [ADDR_W-1:0] vex_node,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic              root_bank
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] TOP_LEVEL = ADDR_W'(N_STEPS - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic              ROOT_BANK = logic'(N_STEPS % 2);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   level_q, level_d;
  logic [ADDR_W-1:0]   j_q, j_d;
  logic                bank_q, bank_d;
  logic                rd_en_q, rd_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Delay line mirrors the RAM-read + evaluation pipeline; entry 0 is the
  // youngest issue, entry PIPE_LAT-1 drives the RAM write port.
  logic [PIPE_LAT-1:0] dl_vld_q, dl_vld_d;
  logic [PIPE_LAT-1:0] dl_bank_q, dl_bank_d;
  logic [ADDR_W-1:0]   dl_addr_q [PIPE_LAT];
  logic [ADDR_W-1:0]   dl_addr_d [PIPE_LAT];

  logic                wr_last;

  // The final write of a level always carries j == level, and writes of a
  // level arrive in issue order, so this marks the level as fully committed.
  assign wr_last = dl_vld_q[PIPE_LAT-1] && (dl_addr_q[PIPE_LAT-1] == level_q);

  // Next-state and next-output logic of the induction sequencer.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    j_d     = j_q;
    bank_d  = bank_q;
    rd_en_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          level_d = TOP_LEVEL;
          j_d     = '0;
          bank_d  = 1'b0;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (j_q == level_q) begin
          state_d = ST_DRAIN;
        end else begin
          j_d     = j_q + ONE;
          rd_en_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Holding issue until the whole level is written avoids any RAW
        // hazard on the bank that the next level reads.
        if (wr_last) begin
          if (level_q == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            level_d = level_q - ONE;
            j_d     = '0;
            bank_d  = ~bank_q;
            rd_en_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state and registered control outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      j_q     <= '0;
      bank_q  <= 1'b0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      j_q     <= j_d;
      bank_q  <= bank_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Shift the write descriptor one stage per cycle, loading it at issue.
  always_comb begin
    dl_vld_d     = dl_vld_q;
    dl_bank_d    = dl_bank_q;
    dl_vld_d[0]  = rd_en_q;
    dl_bank_d[0] = rd_en_q & ~bank_q;
    dl_addr_d[0] = rd_en_q ? j_q : '0;
    for (int i = 1; i < PIPE_LAT; i++) begin
      dl_vld_d[i]  = dl_vld_q[i-1];
      dl_bank_d[i] = dl_bank_q[i-1];
      dl_addr_d[i] = dl_addr_q[i-1];
    end
  end

  // Write-descriptor delay line; reset discards every in-flight write.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dl_vld_q  <= '0;
      dl_bank_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        dl_addr_q[i] <= '0;
      end
    end else begin
      dl_vld_q  <= dl_vld_d;
      dl_bank_q <= dl_bank_d;
      for (int i = 0; i < PIPE_LAT; i++) begin
        dl_addr_q[i] <= dl_addr_d[i];
      end
    end
  end

  // Read-side fields are held at zero whenever no node is being issued.
  assign rd_en      = rd_en_q;
  assign rd_bank    = rd_en_q & bank_q;
  assign rd_addr_dn = rd_en_q ? j_q : '0;
  assign rd_addr_up = rd_en_q ? (j_q + ONE) : '0;
  assign vex_level  = rd_en_q ? level_q : '0;
  assign vex_node   = rd_en_q ? j_q : '0;

  assign wr_en      = dl_vld_q[PIPE_LAT-1];
  assign wr_bank    = dl_bank_q[PIPE_LAT-1];
  assign wr_addr    = dl_addr_q[PIPE_LAT-1];

  assign busy       = busy_q;
  assign done       = done_q;
  assign root_bank  = ROOT_BANK;

endmodule
`default_nettype wire

// File: tb/tb_lattice_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_lattice_sched
// Description : Directed bench for lattice_sched. It uses three instances:
//               A (N=2, lat=3), B (N=1, lat=1) and C (N=64, lat=14). Instance C
//               drives a behavioural value RAM and evaluation model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lattice_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- instance A: N_STEPS=2, PIPE_LAT=3 ----------------
  logic       a_nrst, a_start;
  logic       a_rd_en, a_rd_bank, a_wr_en, a_wr_bank, a_busy, a_done, a_root_bank;
  logic [6:0] a_dn, a_up, a_vl, a_vn, a_wa;

  lattice_sched #(.N_STEPS(2), .ADDR_W(7), .PIPE_LAT(3)) u_a (
    .clk(clk), .nrst(a_nrst), .start(a_start),
    .rd_en(a_rd_en), .rd_bank(a_rd_bank), .rd_addr_dn(a_dn), .rd_addr_up(a_up),
    .vex_level(a_vl), .vex_node(a_vn),
    .wr_en(a_wr_en), .wr_bank(a_wr_bank), .wr_addr(a_wa),
    .busy(a_busy), .done(a_done), .root_bank(a_root_bank)
  );

  // ---------------- instance B: N_STEPS=1, PIPE_LAT=1 ----------------
  logic       b_nrst, b_start;
  logic       b_rd_en, b_rd_bank, b_wr_en, b_wr_bank, b_busy, b_done, b_root_bank;
  logic [6:0] b_dn, b_up, b_vl, b_vn, b_wa;

  lattice_sched #(.N_STEPS(1), .ADDR_W(7), .PIPE_LAT(1)) u_b (
    .clk(clk), .nrst(b_nrst), .start(b_start),
    .rd_en(b_rd_en), .rd_bank(b_rd_bank), .rd_addr_dn(b_dn), .rd_addr_up(b_up),
    .vex_level(b_vl), .vex_node(b_vn),
    .wr_en(b_wr_en), .wr_bank(b_wr_bank), .wr_addr(b_wa),
    .busy(b_busy), .done(b_done), .root_bank(b_root_bank)
  );

  // ---------------- instance C: N_STEPS=64, PIPE_LAT=14 --------------
  localparam int CN  = 64;
  localparam int CPL = 14;
  logic       c_nrst, c_start;
  logic       c_rd_en, c_rd_bank, c_wr_en, c_wr_bank, c_busy, c_done, c_root_bank;
  logic [6:0] c_dn, c_up, c_vl, c_vn, c_wa;

  lattice_sched #(.N_STEPS(CN), .ADDR_W(7), .PIPE_LAT(CPL)) u_c (
    .clk(clk), .nrst(c_nrst), .start(c_start),
    .rd_en(c_rd_en), .rd_bank(c_rd_bank), .rd_addr_dn(c_dn), .rd_addr_up(c_up),
    .vex_level(c_vl), .vex_node(c_vn),
    .wr_en(c_wr_en), .wr_bank(c_wr_bank), .wr_addr(c_wa),
    .busy(c_busy), .done(c_done), .root_bank(c_root_bank)
  );

  // Trace word: {rd_en, rd_bank, dn, up, vex_level, vex_node, wr_en, wr_bank, wr_addr, busy, done}
  function automatic logic [40:0] pk(input logic rd, input logic rb, input logic [6:0] dn,
                                     input logic [6:0] up, input logic [6:0] vl, input logic [6:0] vn,
                                     input logic we, input logic wb, input logic [6:0] wa,
                                     input logic bz, input logic dd);
    return {rd, rb, dn, up, vl, vn, we, wb, wa, bz, dd};
  endfunction

  // Masked view hides read fields without rd_en and write fields without wr_en.
  function automatic logic [40:0] obs_a(input bit masked);
    if (!masked)
      return pk(a_rd_en, a_rd_bank, a_dn, a_up, a_vl, a_vn, a_wr_en, a_wr_bank, a_wa, a_busy, a_done);
    return pk(a_rd_en, a_rd_en & a_rd_bank, a_rd_en ? a_dn : 7'd0, a_rd_en ? a_up : 7'd0,
              a_rd_en ? a_vl : 7'd0, a_rd_en ? a_vn : 7'd0,
              a_wr_en, a_wr_en & a_wr_bank, a_wr_en ? a_wa : 7'd0, a_busy, a_done);
  endfunction

  function automatic logic [40:0] obs_b(input bit masked);
    if (!masked)
      return pk(b_rd_en, b_rd_bank, b_dn, b_up, b_vl, b_vn, b_wr_en, b_wr_bank, b_wa, b_busy, b_done);
    return pk(b_rd_en, b_rd_en & b_rd_bank, b_rd_en ? b_dn : 7'd0, b_rd_en ? b_up : 7'd0,
              b_rd_en ? b_vl : 7'd0, b_rd_en ? b_vn : 7'd0,
              b_wr_en, b_wr_en & b_wr_bank, b_wr_en ? b_wa : 7'd0, b_busy, b_done);
  endfunction

  function automatic logic [40:0] obs_c_raw();
    return pk(c_rd_en, c_rd_bank, c_dn, c_up, c_vl, c_vn, c_wr_en, c_wr_bank, c_wa, c_busy, c_done);
  endfunction

  // Hand-derived trace for N=2, lat=3, with start in cycle 0.
  function automatic logic [40:0] exp_a(input int c);
    case (c)
      1:       return pk(1'b1, 1'b0, 7'd0, 7'd1, 7'd1, 7'd0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
      2:       return pk(1'b1, 1'b0, 7'd1, 7'd2, 7'd1, 7'd1, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
      3, 7, 8: return pk(1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
      4:       return pk(1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b1, 1'b1, 7'd0, 1'b1, 1'b0);
      5:       return pk(1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b1, 1'b1, 7'd1, 1'b1, 1'b0);
      6:       return pk(1'b1, 1'b1, 7'd0, 7'd1, 7'd0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
      9:       return pk(1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0);
      10:      return pk(1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1);
      default: return '0;
    endcase
  endfunction

  // Hand-derived trace for N=1, lat=1.
  function automatic logic [40:0] exp_b(input int c);
    case (c)
      1:       return pk(1'b1, 1'b0, 7'd0, 7'd1, 7'd0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
      2:       return pk(1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b1, 1'b1, 7'd0, 1'b1, 1'b0);
      3:       return pk(1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1);
      default: return '0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Run instance A from a start in cycle 0. Optional extra starts land while busy.
  // An optional reset in cycle rst_at ends the trace early.
  task automatic trace_a(input string name, input bit extra, input int ncyc, input int rst_at);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      a_start = (c == 0) || (extra && (c == 2 || c == 4 || c == 7));
      if (c == rst_at) begin
        a_start = 1'b0;
        a_nrst  = 1'b0;
        #1;
        check({name, " async clear"}, 64'(obs_a(1'b0)), 64'd0);
        return;
      end
      @(negedge clk);
      check($sformatf("%s c%0d", name, c), 64'(obs_a(1'b1)), 64'(exp_a(c)));
    end
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  // ---------------- behavioural price model for instance C ----------------
  function automatic int ex_val(input int i, input int j);
    int s;
    s = 10 - 6 * j + 3 * i;    // strike 110 minus spot 100+3*(2j-i)
    return (s > 0) ? s : 0;
  endfunction

  function automatic int node_val(input int vdn, input int vup, input int i, input int j);
    int cont;
    int e;
    cont = ((vdn + vup) * 63) >>> 7;
    e    = ex_val(i, j);
    return (cont > e) ? cont : e;
  endfunction

  function automatic int ref_price();
    int v [0:CN];
    for (int j = 0; j <= CN; j++) v[j] = ex_val(CN, j);
    for (int i = CN - 1; i >= 0; i--)
      for (int j = 0; j <= i; j++) v[j] = node_val(v[j], v[j+1], i, j);
    return v[0];
  endfunction

  typedef struct {
    logic       bank;
    logic [6:0] addr;
    int         val;
  } pend_t;

  int    ram [2][128];
  pend_t pq [$];

  initial begin
    int    hazards;
    int    wr_bad;
    int    done_cyc;
    int    cyc;
    int    exp_done;
    int    newv;
    bit    have_new;
    pend_t p;

    a_nrst = 1'b0; b_nrst = 1'b0; c_nrst = 1'b0;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset A outputs", 64'(obs_a(1'b0)), 64'd0);
    check("reset B outputs", 64'(obs_b(1'b0)), 64'd0);
    check("reset C outputs", 64'(obs_c_raw()), 64'd0);
    check("root_bank A", 64'(a_root_bank), 64'd0);
    check("root_bank B", 64'(b_root_bank), 64'd1);
    check("root_bank C", 64'(c_root_bank), 64'd0);
    @(posedge clk); #1;
    a_nrst = 1'b1; b_nrst = 1'b1; c_nrst = 1'b1;
    repeat (2) @(posedge clk);

    // Case 1: basic two-level trace
    trace_a("case1", 1'b0, 13, -1);

    // Case 3: starts while busy are ignored
    trace_a("case3", 1'b1, 15, -1);

    // Case 4: reset in cycle 5, then no writes, then a clean rerun
    trace_a("case4", 1'b0, 13, 5);
    repeat (2) @(posedge clk);
    #1 a_nrst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("case4 quiet k%0d", k), 64'(obs_a(1'b0)), 64'd0);
    end
    trace_a("case4 rerun", 1'b0, 13, -1);

    // Case 2: single-level lattice
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      b_start = (c == 0);
      @(negedge clk);
      check($sformatf("case2 c%0d", c), 64'(obs_b(1'b1)), 64'(exp_b(c)));
    end

    // Case 5: full 64-level induction against a behavioural RAM
    for (int b = 0; b < 2; b++)
      for (int j = 0; j < 128; j++) ram[b][j] = 0;
    for (int j = 0; j <= CN; j++) ram[0][j] = ex_val(CN, j);
    hazards  = 0;
    wr_bad   = 0;
    done_cyc = -1;
    cyc      = 0;
    exp_done = 0;
    for (int i = 0; i < CN; i++) exp_done += i + 1 + CPL;
    exp_done = exp_done + 2 - 1;    // inclusive count spans start cycle to done cycle

    @(posedge clk); #1;
    c_start = 1'b1;
    while (done_cyc < 0 && cyc < 5000) begin
      @(negedge clk);
      have_new = 1'b0;
      newv     = 0;
      if (c_rd_en) begin
        foreach (pq[k])
          if (pq[k].bank == c_rd_bank && (pq[k].addr == c_dn || pq[k].addr == c_up))
            hazards++;
        newv = node_val(ram[c_rd_bank][c_dn], ram[c_rd_bank][c_up], int'(c_vl), int'(c_vn));
        have_new = 1'b1;
      end
      if (c_wr_en) begin
        if (pq.size() == 0) begin
          wr_bad++;
        end else begin
          p = pq.pop_front();
          if (p.bank != c_wr_bank || p.addr != c_wa) wr_bad++;
          ram[c_wr_bank][c_wa] = p.val;
        end
      end
      if (have_new) pq.push_back('{~c_rd_bank, c_dn, newv});
      if (c_done) done_cyc = cyc;
      @(posedge clk); #1;
      c_start = 1'b0;
      cyc++;
    end
    check("case5 done cycle", 64'(done_cyc), 64'(exp_done));
    check("case5 RAW hazards", 64'(hazards), 64'd0);
    check("case5 write order", 64'(wr_bad), 64'd0);
    check("case5 pending empty", 64'(pq.size()), 64'd0);
    check("case5 root price", 64'(ram[0][0]), 64'(ref_price()));
    @(negedge clk);
    check("case5 idle after done", 64'(obs_c_raw()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
